// File: rtl/byte_stream_comparator_pkg.sv
// Shared types and constants for the byte-serial magnitude comparator.
// Holds the control FSM state enum, the one-hot cascade-state encoding
// {lt,et,gt} and the helper that sizes the beat counter.
package byte_stream_comparator_pkg;

    // Control FSM: wait for start, stream beats, present verdict.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Cascade state packed as {l, e, g}.
    localparam logic [2:0] CASC_LT = 3'b100;
    localparam logic [2:0] CASC_EQ = 3'b010;
    localparam logic [2:0] CASC_GT = 3'b001;

    // Counter must hold 0..BYTES inclusive.
    function automatic int cnt_width(input int bytes);
        return $clog2(bytes + 1);
    endfunction

endpackage

// File: rtl/byte_stream_comparator_cmp8.sv
// 8-bit cascaded magnitude comparator; the cascade inputs decide only on a tie.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no storage and no handshake.
//
// Ports:
//   i_a, i_b          operands
//   i_l, i_e, i_g     cascade-in relation from more significant stages
//   o_lt, o_et, o_gt  resulting relation, one-hot when the cascade-in is one-hot
module comparator8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_l,
    input  logic       i_e,
    input  logic       i_g,
    output logic       o_lt,
    output logic       o_et,
    output logic       o_gt
);

    always_comb begin
        o_lt = 1'b0;
        o_et = 1'b0;
        o_gt = 1'b0;
        if (i_a > i_b) begin
            o_gt = 1'b1;
        end else if (i_a < i_b) begin
            o_lt = 1'b1;
        end else begin
            // Bytes tie: pass through whatever the cascade-in says.
            o_lt = i_l;
            o_et = i_e;
            o_gt = i_g;
        end
    end

endmodule

// File: rtl/byte_stream_comparator.sv
// Compares two BYTES-wide unsigned operands streamed MSB-first as byte pairs.
// Latency: verdict and done appear the cycle after the last beat is accepted.
// Backpressure: in_ready high only in RUN; in_valid low simply stalls the stream.
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   start              starts a comparison, sampled only while idle
//   in_valid/in_ready  beat handshake for a_byte/b_byte
//   a_byte, b_byte     current operand bytes, most significant first
//   busy               high while a comparison is running or completing
//   done               one-cycle pulse; lt/et/gt valid from this cycle
//   lt, et, gt         held verdict A<B / A==B / A>B
//   byte_cnt           beats accepted in the current comparison
module byte_stream_comparator
    import byte_stream_comparator_pkg::*;
#(
    parameter  int BYTES = 4,
    localparam int CNT_W = cnt_width(BYTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a_byte,
    input  logic [7:0]       b_byte,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             et,
    output logic             gt,
    output logic [CNT_W-1:0] byte_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_casc;
    logic [2:0]       r_res;
    logic [CNT_W-1:0] r_cnt;

    logic             w_byte_lt;
    logic             w_byte_et;
    logic             w_byte_gt;
    logic             w_accept;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_casc_nxt;

    // Per-byte relation only; the running relation lives in r_casc.
    comparator8 u_cmp8 (
        .i_a  (a_byte),
        .i_b  (b_byte),
        .i_l  (1'b0),
        .i_e  (1'b1),
        .i_g  (1'b0),
        .o_lt (w_byte_lt),
        .o_et (w_byte_et),
        .o_gt (w_byte_gt)
    );

    assign w_accept  = (r_state == RUN) && in_valid;
    assign w_cnt_nxt = r_cnt + CNT_W'(1);
    assign w_last    = (w_cnt_nxt == CNT_W'(BYTES));

    // Once a more significant byte has decided, later bytes cannot change it.
    assign w_casc_nxt = (r_casc == CASC_EQ) ? {w_byte_lt, w_byte_et, w_byte_gt}
                                            : r_casc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_accept && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_casc <= CASC_EQ;
            r_cnt  <= '0;
            r_res  <= 3'b000;
        end else if ((r_state == IDLE) && start) begin
            r_casc <= CASC_EQ;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_casc <= w_casc_nxt;
            r_cnt  <= w_cnt_nxt;
            // Load the verdict with the final beat so it is valid alongside done.
            if (w_last) begin
                r_res <= w_casc_nxt;
            end
        end
    end

    // Status outputs decode the state register only: no input-to-output path.
    assign in_ready     = (r_state == RUN);
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);
    assign {lt, et, gt} = r_res;
    assign byte_cnt     = r_cnt;

endmodule

// File: tb/tb_byte_stream_comparator.sv
module tb_byte_stream_comparator;

    localparam int BYTES = 4;
    localparam int CNT_W = $clog2(BYTES + 1);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a_byte;
    logic [7:0]       b_byte;
    logic             busy;
    logic             done;
    logic             lt;
    logic             et;
    logic             gt;
    logic [CNT_W-1:0] byte_cnt;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [2:0] held    = 3'b000;   // verdict the outputs must currently hold

    byte_stream_comparator #(.BYTES(BYTES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_byte   (a_byte),
        .b_byte   (b_byte),
        .busy     (busy),
        .done     (done),
        .lt       (lt),
        .et       (et),
        .gt       (gt),
        .byte_cnt (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference verdict straight from the integer relation of the full operands.
    function automatic logic [2:0] ref_verdict(input logic [31:0] a, input logic [31:0] b);
        if (a < b)       return 3'b100;
        else if (a == b) return 3'b010;
        else             return 3'b001;
    endfunction

    // Runs one full comparison. Entered and left at a negedge in an IDLE cycle.
    task automatic do_compare(input logic [31:0] a, input logic [31:0] b,
                              input int stall_min, input int stall_max,
                              input bit start_w_valid, input bit poke_start);
        logic [2:0] exp_v;
        int         cyc;
        int         ns;
        bit         stalled;
        exp_v   = ref_verdict(a, b);
        stalled = 1'b0;
        start    = 1'b1;
        in_valid = start_w_valid;
        a_byte   = a[31:24];
        b_byte   = b[31:24];
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        start    = 1'b0;
        in_valid = 1'b0;
        check("run_busy", 32'(busy), 1);
        check("run_rdy", 32'(in_ready), 1);
        check("cnt_clr", 32'(byte_cnt), 0);
        check("held_run", 32'({lt, et, gt}), 32'(held));
        for (int i = 0; i < BYTES; i++) begin
            ns = $urandom_range(stall_max, stall_min);
            for (int s = 0; s < ns; s++) begin
                stalled  = 1'b1;
                in_valid = 1'b0;
                start    = poke_start;
                a_byte   = 8'($urandom);
                b_byte   = 8'($urandom);
                @(negedge clk);
                cyc++;
                check("stall_cnt", 32'(byte_cnt), 32'(i));
                check("stall_rdy", 32'(in_ready), 1);
                check("stall_v", 32'({lt, et, gt}), 32'(held));
                check("stall_done", 32'(done), 0);
            end
            in_valid = 1'b1;
            start    = poke_start;
            a_byte   = a[8*(BYTES-1-i) +: 8];
            b_byte   = b[8*(BYTES-1-i) +: 8];
            @(negedge clk);
            cyc++;
            in_valid = 1'b0;
            start    = poke_start;
            check("beat_cnt", 32'(byte_cnt), 32'(i + 1));
            if (i < BYTES - 1) begin
                check("beat_rdy", 32'(in_ready), 1);
                check("beat_done", 32'(done), 0);
                check("beat_v", 32'({lt, et, gt}), 32'(held));
            end
        end
        // DONE cycle
        check("done", 32'(done), 1);
        check("verdict", 32'({lt, et, gt}), 32'(exp_v));
        check("done_rdy", 32'(in_ready), 0);
        check("done_busy", 32'(busy), 1);
        if (!stalled) check("latency", 32'(cyc), 32'(BYTES + 1));
        held = exp_v;
        @(negedge clk);
        start = 1'b0;
        check("idle_done", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_v", 32'({lt, et, gt}), 32'(held));
        check("idle_cnt", 32'(byte_cnt), 32'(BYTES));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          mode;
        int          k;

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        a_byte   = 8'h00;
        b_byte   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_rdy", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_v", 32'({lt, et, gt}), 0);
        check("rst_cnt", 32'(byte_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed scenarios
        do_compare(32'h01020304, 32'h01020304, 0, 0, 1'b0, 1'b0);
        do_compare(32'h80000000, 32'h7FFFFFFF, 0, 0, 1'b0, 1'b0);
        do_compare(32'h12345601, 32'h12345602, 3, 3, 1'b0, 1'b0);
        do_compare(32'hA5A5A5A5, 32'hA5A5A5A4, 0, 1, 1'b1, 1'b0);  // start+valid together
        do_compare(32'h00FF0000, 32'h01000000, 0, 2, 1'b0, 1'b1);  // start held in RUN/DONE

        // in_valid while idle consumes nothing
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a_byte   = 8'($urandom);
            b_byte   = 8'($urandom);
            @(negedge clk);
            check("iv_idle_rdy", 32'(in_ready), 0);
            check("iv_idle_busy", 32'(busy), 0);
            check("iv_idle_cnt", 32'(byte_cnt), 32'(BYTES));
            check("iv_idle_v", 32'({lt, et, gt}), 32'(held));
        end
        in_valid = 1'b0;

        // Reset after two beats
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        a_byte   = 8'h55;
        b_byte   = 8'h55;
        repeat (2) @(negedge clk);
        check("pre_rst_cnt", 32'(byte_cnt), 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", 32'(in_ready), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_v", 32'({lt, et, gt}), 0);
        check("mid_rst_cnt", 32'(byte_cnt), 0);
        held = 3'b000;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 0);
        do_compare(32'h00000002, 32'h00000001, 0, 0, 1'b0, 1'b0);

        // Randomized back-to-back comparisons, operands biased toward shared prefixes
        for (int n = 0; n < 60; n++) begin
            ra   = $urandom;
            mode = $urandom_range(3, 0);
            case (mode)
                0: rb = $urandom;
                1: rb = ra;
                default: begin
                    rb = ra;
                    k  = $urandom_range(BYTES - 1, 0);
                    rb[8*k +: 8] = 8'($urandom);
                end
            endcase
            do_compare(ra, rb, 0, (n % 3), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule
